first_system_pair_deserializer: RTL and testbench
=================================================

// Module: first_system_pair_deserializer
// PURPOSE
//  Receive-side counterpart of the first_system two-wire encoder, which drives out1 = in1^in2 and out2 = ~in2.
//  Accepts one encoded symbol pair (sym_out1, sym_out2) per handshake and inverts the encoding:
//  in2 = ~out2, in1 = out1 ^ ~out2.
//  Packs DATA_W/2 decoded pairs into one word and presents it on a valid/ready output port.
//  Sits between the link input and the word-level consumer.
// PARAMETERS
//  DATA_W   8   output word width; even, >= 2; PAIRS = DATA_W/2 symbol pairs per word
//  CNT_W    16  width of the delivered-word counter (saturating)
// PORTS
//  clk         in   1       single clock; all state updates on rising edge
//  rst         in   1       synchronous, active-high reset
//  sym_valid   in   1       symbol pair present on sym_out1/sym_out2
//  sym_ready   out  1       block can accept the symbol pair this cycle
//  sym_out1    in   1       encoded bit 1 (in1^in2)
//  sym_out2    in   1       encoded bit 2 (~in2)
//  sym_sof     in   1       qualifies the pair as the first pair of a word
//  word_data   out  DATA_W  assembled decoded word
//  word_valid  out  1       word_data valid; held until accepted
//  word_ready  in   1       consumer accepts word this cycle
//  sync_err    out  1       one-cycle pulse: partial word discarded by sym_sof
//  word_cnt    out  CNT_W   count of words accepted by the consumer; saturates at all-ones
// BEHAVIOUR
//  Reset values
//   - word_valid=0, word_data=0, sync_err=0, word_cnt=0, pair index=0, accumulator=0.
//   - Reset mid-word or with word_valid high discards all held data.
//  Transfers
//   - Symbol transfer: sym_valid & sym_ready at a rising edge.
//   - Word transfer: word_valid & word_ready.
//  Decode and packing
//   - Pair k of a word (k=0 first) writes word[2k+1]=in1 and word[2k]=in2.
//  Accumulation
//   - State is pair index idx (0..PAIRS-1) plus an accumulator separate from the output register.
//   - Non-final pairs (idx<PAIRS-1) are always accepted, even while word_valid is high.
//  Final pair (idx==PAIRS-1)
//   - Accumulator plus the final pair load word_data.
//   - word_valid=1 from the next cycle; latency is 1 clk from the final symbol edge.
//   - idx returns to 0.
//  sym_ready (combinational)
//   - sym_ready = ~(idx==PAIRS-1 & word_valid & ~word_ready).
//   - A same-cycle word transfer and final-pair load is legal: back-to-back words at one pair per clk.
//  Output register
//   - word_valid clears on a word transfer unless a new word loads on the same edge.
//   - word_data is stable while word_valid & ~word_ready.
//  sym_sof
//   - sym_sof on an accepted pair with idx!=0: discard the accumulator, treat the pair as pair 0,
//     and pulse sync_err high for exactly the next cycle.
//   - sym_sof at idx==0 is normal.
//   - A pair without sym_sof at idx==0 is accepted as free-running stream.
//   - With PAIRS==1 every pair is final; sym_sof never raises sync_err.
//  word_cnt
//   - Increments on each word transfer.
//   - Holds at 2^CNT_W-1.
// STRUCTURE
//  Include file first_system_defs.vh
//   - Encode/decode bit-position constants (IN1_BIT=1, IN2_BIT=0).
//   - Default DATA_W.
//  Sub-module first_system_pair_decoder
//   - Combinational (out1,out2) -> (in1,in2).
//   - Reused by future link blocks.
//  Top level
//   - Index counter, accumulator, output register, sof/sync_err logic, word counter.
// TESTING (DATA_W=8)
//  1. Word 0xB4, word_ready=1: pairs (0,1),(1,0),(0,0),(1,1) on 4 consecutive clks, sof on first
//     -> word_data=0xB4, word_valid for 1 clk after 4th edge, word_cnt=1.
//  2. Back-to-back stream 0xB4 then 0x4B, word_ready=1, sym_valid=1 continuously
//     -> sym_ready never drops; words 1 clk after pair 4 and pair 8.
//  3. Backpressure: word_ready=0 after first word, send 4 more pairs
//     -> 3 pairs accepted; sym_ready=0 on 4th until word_ready=1; 0xB4 stable throughout; next word correct.
//  4. Mid-word resync: 2 pairs, then sof with 4 pairs for 0xFF (all (0,0))
//     -> sync_err pulse 1 clk; word_data=0xFF; no partial word emitted.
//  5. rst for 1 clk after 2 pairs with word_valid=1
//     -> all outputs 0 next cycle; next 4 pairs yield a correct word.
//  6. CNT_W=2: 5 words delivered -> word_cnt saturates at 3.

Source files
------------

// File: rtl/first_system_pair_deserializer_pkg.sv
// Shared constants for the first_system two-wire link: bit positions of the
// decoded pair inside a packed word, default widths, and index sizing.
package first_system_pair_deserializer_pkg;

    localparam int IN1_BIT        = 1;
    localparam int IN2_BIT        = 0;
    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_CNT_W  = 16;

    // A one-pair word still needs a 1-bit index register.
    function automatic int idx_width(input int pairs);
        return (pairs > 1) ? $clog2(pairs) : 1;
    endfunction

endpackage

// File: rtl/first_system_pair_decoder.sv
// Combinational inverse of the first_system encoder
// (out1 = in1^in2, out2 = ~in2), kept separate so other link blocks can reuse it.
module first_system_pair_decoder (
    input  logic out1,
    input  logic out2,
    output logic in1,
    output logic in2
);

    assign in2 = ~out2;
    assign in1 = out1 ^ ~out2;

endmodule

// File: rtl/first_system_pair_deserializer.sv
// Decodes encoded symbol pairs and packs DATA_W/2 of them into a word that is
// offered on a valid/ready port; sym_sof resynchronises a partially built word.
module first_system_pair_deserializer
    import first_system_pair_deserializer_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sym_valid,
    output logic              sym_ready,
    input  logic              sym_out1,
    input  logic              sym_out2,
    input  logic              sym_sof,
    output logic [DATA_W-1:0] word_data,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              sync_err,
    output logic [CNT_W-1:0]  word_cnt
);

    localparam int               PAIRS    = DATA_W / 2;
    localparam int               IDX_W    = idx_width(PAIRS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAIRS - 1);

    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_next;
    logic [IDX_W-1:0]  pair_idx;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_next;
    logic [DATA_W-1:0] merged;
    logic              in1;
    logic              in2;
    logic              sym_fire;
    logic              resync;
    logic              is_final;
    logic              load;
    logic              word_take;

    first_system_pair_decoder u_decoder (
        .out1 (sym_out1),
        .out2 (sym_out2),
        .in1  (in1),
        .in2  (in2)
    );

    // Only the final pair can be stalled: it needs the output register free.
    assign sym_ready = ~((idx == LAST_IDX) & word_valid & ~word_ready);

    always_comb begin
        sym_fire  = sym_valid & sym_ready;
        word_take = word_valid & word_ready;
        resync    = sym_fire & sym_sof & (idx != '0);
        pair_idx  = sym_sof ? '0 : idx;
        is_final  = (pair_idx == LAST_IDX);
        load      = sym_fire & is_final;

        // A resync throws away whatever the accumulator already holds.
        merged = resync ? '0 : acc;
        for (int k = 0; k < PAIRS; k++) begin
            if (pair_idx == IDX_W'(k)) begin
                merged[2*k + IN1_BIT] = in1;
                merged[2*k + IN2_BIT] = in2;
            end
        end

        idx_next = idx;
        acc_next = acc;
        if (sym_fire) begin
            if (is_final) begin
                idx_next = '0;
                acc_next = '0;
            end else begin
                idx_next = pair_idx + IDX_W'(1);
                acc_next = merged;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= '0;
            acc        <= '0;
            word_data  <= '0;
            word_valid <= 1'b0;
            sync_err   <= 1'b0;
            word_cnt   <= '0;
        end else begin
            idx      <= idx_next;
            acc      <= acc_next;
            sync_err <= resync;

            // A new load wins over the clear from a same-edge word transfer.
            if (load) begin
                word_data  <= merged;
                word_valid <= 1'b1;
            end else if (word_take) begin
                word_valid <= 1'b0;
            end

            if (word_take && (word_cnt != '1)) begin
                word_cnt <= word_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_first_system_pair_deserializer.sv
// Directed bench for first_system_pair_deserializer (DATA_W=8) plus a CNT_W=2
// instance sharing the same stimulus to observe counter saturation.
module tb_first_system_pair_deserializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sym_valid = 1'b0;
    logic        sym_out1 = 1'b0;
    logic        sym_out2 = 1'b0;
    logic        sym_sof = 1'b0;
    logic        word_ready = 1'b1;

    logic        sym_ready;
    logic [7:0]  word_data;
    logic        word_valid;
    logic        sync_err;
    logic [15:0] word_cnt;

    logic        sat_sym_ready;
    logic [7:0]  sat_word_data;
    logic        sat_word_valid;
    logic        sat_sync_err;
    logic [1:0]  sat_word_cnt;

    int tests_run = 0;
    int tests_failed = 0;
    int stalls;
    int stalls_a;
    int stalls_b;

    first_system_pair_deserializer #(.DATA_W(8), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .sym_valid  (sym_valid),
        .sym_ready  (sym_ready),
        .sym_out1   (sym_out1),
        .sym_out2   (sym_out2),
        .sym_sof    (sym_sof),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .sync_err   (sync_err),
        .word_cnt   (word_cnt)
    );

    first_system_pair_deserializer #(.DATA_W(8), .CNT_W(2)) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .sym_valid  (sym_valid),
        .sym_ready  (sat_sym_ready),
        .sym_out1   (sym_out1),
        .sym_out2   (sym_out2),
        .sym_sof    (sym_sof),
        .word_data  (sat_word_data),
        .word_valid (sat_word_valid),
        .word_ready (word_ready),
        .sync_err   (sat_sync_err),
        .word_cnt   (sat_word_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Encoder side of the link: out1 = in1^in2, out2 = ~in2.
    function automatic logic [1:0] encPair(input logic [7:0] w, input int k);
        logic in1;
        logic in2;
        in1 = w[2*k + 1];
        in2 = w[2*k];
        return {in1 ^ in2, ~in2};
    endfunction

    task automatic applyStimulus(input logic o1, input logic o2, input logic sof, output int waited);
        sym_valid = 1'b1;
        sym_out1  = o1;
        sym_out2  = o2;
        sym_sof   = sof;
        waited    = 0;
        @(negedge clk);
        while (!sym_ready && waited < 40) begin
            waited++;
            @(negedge clk);
        end
        if (!sym_ready) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL sym_ready_timeout: got 0x0, expected 0x1");
        end
        @(posedge clk);
        #1;
        sym_valid = 1'b0;
        sym_sof   = 1'b0;
    endtask

    task automatic sendWord(input logic [7:0] w, input logic sof, output int waited);
        logic [1:0] p;
        int         s;
        waited = 0;
        for (int k = 0; k < 4; k++) begin
            p = encPair(w, k);
            applyStimulus(p[1], p[0], (k == 0) ? sof : 1'b0, s);
            waited += s;
        end
    endtask

    task automatic idleCycle();
        sym_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got 0x0, expected 0x1");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_word_valid", 32'(word_valid), 0);
        checkOutput("rst_word_data", 32'(word_data), 0);
        checkOutput("rst_sync_err", 32'(sync_err), 0);
        checkOutput("rst_word_cnt", 32'(word_cnt), 0);
        checkOutput("rst_sym_ready", 32'(sym_ready), 1);
        checkOutput("rst_sat_cnt", 32'(sat_word_cnt), 0);
        checkOutput("rst_sat_data", 32'(sat_word_data), 0);
        checkOutput("rst_sat_sync_err", 32'(sat_sync_err), 0);
        checkOutput("rst_sat_ready", 32'(sat_sym_ready), 1);
        rst = 1'b0;

        // Single word 0xB4 with sof on pair 0
        word_ready = 1'b1;
        sendWord(8'hB4, 1'b1, stalls);
        checkOutput("t1_valid", 32'(word_valid), 1);
        checkOutput("t1_data", 32'(word_data), 'hB4);
        checkOutput("t1_cnt_before", 32'(word_cnt), 0);
        idleCycle();
        checkOutput("t1_valid_drop", 32'(word_valid), 0);
        checkOutput("t1_cnt", 32'(word_cnt), 1);

        // Back-to-back stream with no gaps
        sendWord(8'hB4, 1'b0, stalls_a);
        checkOutput("t2_data0", 32'(word_data), 'hB4);
        checkOutput("t2_valid0", 32'(word_valid), 1);
        sendWord(8'h4B, 1'b0, stalls_b);
        checkOutput("t2_data1", 32'(word_data), 'h4B);
        checkOutput("t2_valid1", 32'(word_valid), 1);
        checkOutput("t2_no_stall", 32'(stalls_a + stalls_b), 0);
        checkOutput("t2_cnt_mid", 32'(word_cnt), 2);
        idleCycle();
        checkOutput("t2_cnt", 32'(word_cnt), 3);
        checkOutput("t2_valid_drop", 32'(word_valid), 0);

        // Backpressure: three pairs slip in, the final pair waits
        word_ready = 1'b0;
        sendWord(8'hB4, 1'b0, stalls);
        checkOutput("t3_valid", 32'(word_valid), 1);
        checkOutput("t3_data", 32'(word_data), 'hB4);
        for (int k = 0; k < 3; k++) begin
            logic [1:0] p;
            p = encPair(8'h4B, k);
            applyStimulus(p[1], p[0], 1'b0, stalls);
            checkOutput("t3_pair_stall", 32'(stalls), 0);
            checkOutput("t3_hold_data", 32'(word_data), 'hB4);
            checkOutput("t3_hold_valid", 32'(word_valid), 1);
        end
        sym_valid = 1'b1;
        sym_out1  = 1'b1;
        sym_out2  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("t3_blocked_ready", 32'(sym_ready), 0);
            checkOutput("t3_blocked_data", 32'(word_data), 'hB4);
            checkOutput("t3_blocked_valid", 32'(word_valid), 1);
        end
        word_ready = 1'b1;
        #1;
        checkOutput("t3_released_ready", 32'(sym_ready), 1);
        @(posedge clk);
        #1;
        sym_valid = 1'b0;
        checkOutput("t3_next_valid", 32'(word_valid), 1);
        checkOutput("t3_next_data", 32'(word_data), 'h4B);
        checkOutput("t3_cnt_mid", 32'(word_cnt), 4);
        idleCycle();
        checkOutput("t3_cnt", 32'(word_cnt), 5);

        // Mid-word resync: two pairs of 0xB4, then 0xFF from a fresh sof
        applyStimulus(1'b0, 1'b1, 1'b1, stalls);
        applyStimulus(1'b1, 1'b0, 1'b0, stalls);
        checkOutput("t4_no_err_yet", 32'(sync_err), 0);
        applyStimulus(1'b0, 1'b0, 1'b1, stalls);
        checkOutput("t4_sync_err", 32'(sync_err), 1);
        checkOutput("t4_no_partial", 32'(word_valid), 0);
        applyStimulus(1'b0, 1'b0, 1'b0, stalls);
        checkOutput("t4_err_pulse_end", 32'(sync_err), 0);
        checkOutput("t4_still_no_word", 32'(word_valid), 0);
        applyStimulus(1'b0, 1'b0, 1'b0, stalls);
        checkOutput("t4_third_no_word", 32'(word_valid), 0);
        applyStimulus(1'b0, 1'b0, 1'b0, stalls);
        checkOutput("t4_valid", 32'(word_valid), 1);
        checkOutput("t4_data", 32'(word_data), 'hFF);
        idleCycle();
        checkOutput("t4_cnt", 32'(word_cnt), 6);

        // Reset with a held word and a half-built accumulator
        word_ready = 1'b0;
        sendWord(8'hB4, 1'b1, stalls);
        checkOutput("t5_held", 32'(word_valid), 1);
        applyStimulus(1'b0, 1'b0, 1'b0, stalls);
        applyStimulus(1'b1, 1'b1, 1'b0, stalls);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("t5_rst_valid", 32'(word_valid), 0);
        checkOutput("t5_rst_data", 32'(word_data), 0);
        checkOutput("t5_rst_cnt", 32'(word_cnt), 0);
        checkOutput("t5_rst_sync_err", 32'(sync_err), 0);
        checkOutput("t5_rst_ready", 32'(sym_ready), 1);
        checkOutput("t5_rst_sat_cnt", 32'(sat_word_cnt), 0);
        word_ready = 1'b1;
        sendWord(8'h4B, 1'b0, stalls);
        checkOutput("t5_after_valid", 32'(word_valid), 1);
        checkOutput("t5_after_data", 32'(word_data), 'h4B);
        idleCycle();
        checkOutput("t5_cnt", 32'(word_cnt), 1);
        checkOutput("t5_sat_cnt", 32'(sat_word_cnt), 1);

        // Saturation on the CNT_W=2 instance
        sendWord(8'hB4, 1'b0, stalls);
        sendWord(8'h4B, 1'b0, stalls);
        sendWord(8'hFF, 1'b0, stalls);
        checkOutput("t6_sat_data", 32'(sat_word_data), 'hFF);
        idleCycle();
        checkOutput("t6_cnt4", 32'(word_cnt), 4);
        checkOutput("t6_sat_cnt4", 32'(sat_word_cnt), 3);
        sendWord(8'hB4, 1'b0, stalls);
        idleCycle();
        checkOutput("t6_cnt5", 32'(word_cnt), 5);
        checkOutput("t6_sat_cnt5", 32'(sat_word_cnt), 3);
        checkOutput("t6_sat_valid", 32'(sat_word_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
